// File: rtl/memory_cycle.sv
// memory_cycle: memory pipeline stage between execute and writeback.
// Non-memory instructions pass the ALU result straight through in one cycle.
// Loads and stores run a req/ack handshake with data memory, stalling upstream
// until the ack (or a timeout abort) retires the instruction.
//
// Ports:
//   clk, rst         clock, async active-high reset
//   aluout, bout     ALU result (result / memory address) and store data
//   rdin, regwrite   destination register and its write enable
//   valid_in         live instruction from execute
//   memread/memwrite load / store select
//   mem_rdata/ack    data memory response
//   mem_req/we/addr/wdata  data memory request
//   stall            combinational hold request to upstream stages
//   wbdata, rdout, regwrite_out, valid_out  writeback payload
//   err              sticky error (illegal op or timeout)
module memory_cycle #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned RD_W    = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] aluout,
   input  logic [DATA_W-1:0] bout,
   input  logic [RD_W-1:0]   rdin,
   input  logic              valid_in,
   input  logic              memread,
   input  logic              memwrite,
   input  logic              regwrite,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              stall,
   output logic [DATA_W-1:0] wbdata,
   output logic [RD_W-1:0]   rdout,
   output logic              regwrite_out,
   output logic              valid_out,
   output logic              err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] wbdata_q, wbdata_d;
   logic [RD_W-1:0]   rdout_q, rdout_d;
   logic              regwrite_q, regwrite_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic [RD_W-1:0]   rd_lat_q, rd_lat_d;
   logic              ld_wr_q, ld_wr_d;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wbdata_q    <= '0;
         rdout_q     <= '0;
         regwrite_q  <= 1'b0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         rd_lat_q    <= '0;
         ld_wr_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wbdata_q    <= wbdata_d;
         rdout_q     <= rdout_d;
         regwrite_q  <= regwrite_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         rd_lat_q    <= rd_lat_d;
         ld_wr_q     <= ld_wr_d;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wbdata_d    = wbdata_q;
      rdout_d     = rdout_q;
      regwrite_d  = 1'b0;
      valid_d     = 1'b0;
      err_d       = err_q;
      rd_lat_d    = rd_lat_q;
      ld_wr_d     = ld_wr_q;

      case (state_q)
         IDLE: begin
            if (valid_in) begin
               if (memread && memwrite) begin
                  // Illegal: retire as a no-op with the error flag set
                  err_d   = 1'b1;
                  valid_d = 1'b1;
               end else if (memread || memwrite) begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = memwrite;
                  mem_addr_d  = aluout;
                  mem_wdata_d = bout;
                  rd_lat_d    = rdin;
                  ld_wr_d     = regwrite & memread;
                  cnt_d       = '0;
                  state_d     = ACCESS;
               end else begin
                  wbdata_d   = aluout;
                  rdout_d    = rdin;
                  regwrite_d = regwrite;
                  valid_d    = 1'b1;
               end
            end
         end
         ACCESS: begin
            // Ack takes priority over a coincident timeout
            if (mem_ack) begin
               mem_req_d  = 1'b0;
               if (!mem_we_q) begin
                  wbdata_d = mem_rdata;
               end
               rdout_d    = rd_lat_q;
               regwrite_d = ld_wr_q;
               valid_d    = 1'b1;
               state_d    = IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               valid_d   = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign stall        = (state_q == ACCESS);
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign wbdata       = wbdata_q;
   assign rdout        = rdout_q;
   assign regwrite_out = regwrite_q;
   assign valid_out    = valid_q;
   assign err          = err_q;

endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: directed self-checking bench for memory_cycle.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_memory_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] aluout, bout, mem_rdata;
   logic [3:0]  rdin;
   logic        valid_in, memread, memwrite, regwrite, mem_ack;
   logic        mem_req, mem_we, stall, regwrite_out, valid_out, err;
   logic [15:0] mem_addr, mem_wdata, wbdata;
   logic [3:0]  rdout;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   memory_cycle #(.DATA_W(16), .RD_W(4), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .aluout(aluout), .bout(bout), .rdin(rdin),
      .valid_in(valid_in), .memread(memread), .memwrite(memwrite),
      .regwrite(regwrite), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .stall(stall), .wbdata(wbdata), .rdout(rdout),
      .regwrite_out(regwrite_out), .valid_out(valid_out), .err(err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_in = 1'b0; memread = 1'b0; memwrite = 1'b0; regwrite = 1'b0;
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] rd,
                        input logic rw, input logic mr, input logic mw);
      aluout = a; bout = b; rdin = rd; regwrite = rw;
      memread = mr; memwrite = mw; valid_in = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle_inputs(); mem_ack = 1'b0; mem_rdata = '0;
      aluout = '0; bout = '0; rdin = '0;
      step();
      total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %b exp 0", mem_req); else passed++;
      total++; if (wbdata !== 16'h0 || rdout !== 4'h0) $display("FAIL rst_wb got %h/%h exp 0/0", wbdata, rdout); else passed++;
      total++; if ({valid_out, regwrite_out, err, stall} !== 4'b0) $display("FAIL rst_flags got %b exp 0000", {valid_out, regwrite_out, err, stall}); else passed++;
      total++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || mem_we !== 1'b0) $display("FAIL rst_mem_bus got %h/%h/%b exp 0", mem_addr, mem_wdata, mem_we); else passed++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_passthrough();
      issue(16'h1234, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0);
      step();
      idle_inputs();
      total++; if (wbdata !== 16'h1234) $display("FAIL pt_wbdata got %h exp 1234", wbdata); else passed++;
      total++; if (rdout !== 4'd3) $display("FAIL pt_rdout got %0d exp 3", rdout); else passed++;
      total++; if ({regwrite_out, valid_out, stall, mem_req} !== 4'b1100) $display("FAIL pt_flags got %b exp 1100", {regwrite_out, valid_out, stall, mem_req}); else passed++;
      step();
      total++; if ({valid_out, regwrite_out} !== 2'b00 || wbdata !== 16'h1234 || rdout !== 4'd3) $display("FAIL pt_hold got v%b r%b %h %0d exp v0 r0 1234 3", valid_out, regwrite_out, wbdata, rdout); else passed++;
   endtask

   task automatic test_back_to_back();
      issue(16'h1111, 16'h0, 4'd1, 1'b0, 1'b0, 1'b0);
      step();
      total++; if (wbdata !== 16'h1111 || rdout !== 4'd1 || valid_out !== 1'b1 || regwrite_out !== 1'b0) $display("FAIL b2b_first got %h %0d v%b r%b exp 1111 1 v1 r0", wbdata, rdout, valid_out, regwrite_out); else passed++;
      issue(16'h2222, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0);
      step();
      idle_inputs();
      total++; if (wbdata !== 16'h2222 || rdout !== 4'd2 || valid_out !== 1'b1 || regwrite_out !== 1'b1) $display("FAIL b2b_second got %h %0d v%b r%b exp 2222 2 v1 r1", wbdata, rdout, valid_out, regwrite_out); else passed++;
      step();
   endtask

   task automatic test_load();
      issue(16'h0040, 16'h0, 4'd5, 1'b1, 1'b1, 1'b0);
      step();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040 || stall !== 1'b1 || valid_out !== 1'b0)
            $display("FAIL ld_wait%0d got req%b we%b %h st%b v%b exp req1 we0 0040 st1 v0", i, mem_req, mem_we, mem_addr, stall, valid_out);
         else passed++;
         if (i == 2) begin
            mem_ack = 1'b1; mem_rdata = 16'hBEEF;
         end
         step();
      end
      mem_ack = 1'b0; mem_rdata = 16'h0;
      total++; if (wbdata !== 16'hBEEF || rdout !== 4'd5) $display("FAIL ld_data got %h %0d exp beef 5", wbdata, rdout); else passed++;
      total++; if ({mem_req, stall, valid_out, regwrite_out} !== 4'b0011) $display("FAIL ld_done got %b exp 0011", {mem_req, stall, valid_out, regwrite_out}); else passed++;
      step();
      total++; if (valid_out !== 1'b0) $display("FAIL ld_pulse got %b exp 0", valid_out); else passed++;
   endtask

   task automatic test_store();
      issue(16'h0008, 16'h00AA, 4'd7, 1'b1, 1'b0, 1'b1);
      step();
      idle_inputs();
      total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h00AA || mem_addr !== 16'h0008 || stall !== 1'b1)
         $display("FAIL st_req got req%b we%b %h %h st%b exp req1 we1 00aa 0008 st1", mem_req, mem_we, mem_wdata, mem_addr, stall);
      else passed++;
      mem_ack = 1'b1; mem_rdata = 16'h5555;
      step();
      mem_ack = 1'b0;
      total++; if ({valid_out, regwrite_out, mem_req, stall} !== 4'b1000) $display("FAIL st_done got %b exp 1000", {valid_out, regwrite_out, mem_req, stall}); else passed++;
      total++; if (wbdata !== 16'hBEEF || rdout !== 4'd7) $display("FAIL st_wb got %h %0d exp beef 7", wbdata, rdout); else passed++;
   endtask

   task automatic test_ack_in_idle();
      mem_ack = 1'b1; mem_rdata = 16'h9999;
      step();
      step();
      mem_ack = 1'b0;
      total++; if ({mem_req, valid_out, stall} !== 3'b000 || wbdata !== 16'hBEEF) $display("FAIL idle_ack got %b %h exp 000 beef", {mem_req, valid_out, stall}, wbdata); else passed++;
   endtask

   task automatic test_ack_timeout_race();
      logic held = 1'b1;
      issue(16'h0100, 16'h0, 4'd9, 1'b1, 1'b1, 1'b0);
      step();
      idle_inputs();
      for (int i = 0; i < 14; i++) begin
         if (mem_req !== 1'b1) held = 1'b0;
         step();
      end
      total++; if (held !== 1'b1 || mem_req !== 1'b1) $display("FAIL race_held got %b%b exp 11", held, mem_req); else passed++;
      mem_ack = 1'b1; mem_rdata = 16'h5A5A;
      step();
      mem_ack = 1'b0;
      total++; if ({valid_out, regwrite_out, err, mem_req} !== 4'b1100) $display("FAIL race_done got %b exp 1100", {valid_out, regwrite_out, err, mem_req}); else passed++;
      total++; if (wbdata !== 16'h5A5A || rdout !== 4'd9) $display("FAIL race_wb got %h %0d exp 5a5a 9", wbdata, rdout); else passed++;
      step();
   endtask

   task automatic test_timeout();
      int n = 0;
      issue(16'h0200, 16'h0, 4'd6, 1'b1, 1'b1, 1'b0);
      step();
      idle_inputs();
      for (int i = 0; i < 40; i++) begin
         if (mem_req !== 1'b1) break;
         n++;
         step();
      end
      total++; if (n !== 15) $display("FAIL to_cycles got %0d exp 15", n); else passed++;
      total++; if ({err, valid_out, regwrite_out, stall} !== 4'b1100) $display("FAIL to_flags got %b exp 1100", {err, valid_out, regwrite_out, stall}); else passed++;
      total++; if (wbdata !== 16'h5A5A) $display("FAIL to_wb got %h exp 5a5a", wbdata); else passed++;
      issue(16'h7777, 16'h0, 4'd4, 1'b1, 1'b0, 1'b0);
      step();
      idle_inputs();
      step();
      total++; if (err !== 1'b1 || wbdata !== 16'h7777) $display("FAIL to_sticky got err%b %h exp err1 7777", err, wbdata); else passed++;
   endtask

   task automatic test_illegal();
      rst = 1'b1;
      #2;
      total++; if (err !== 1'b0) $display("FAIL il_clr got %b exp 0", err); else passed++;
      step();
      rst = 1'b0;
      issue(16'h0300, 16'h0033, 4'd8, 1'b1, 1'b1, 1'b1);
      step();
      idle_inputs();
      total++; if ({mem_req, err, valid_out, regwrite_out, stall} !== 5'b01100) $display("FAIL il_flags got %b exp 01100", {mem_req, err, valid_out, regwrite_out, stall}); else passed++;
      step();
      total++; if ({mem_req, valid_out, err} !== 3'b001) $display("FAIL il_after got %b exp 001", {mem_req, valid_out, err}); else passed++;
   endtask

   task automatic test_reset_mid_access();
      rst = 1'b1;
      step();
      rst = 1'b0;
      issue(16'h0040, 16'h0, 4'd5, 1'b1, 1'b1, 1'b0);
      step();
      idle_inputs();
      step();
      step();
      total++; if (mem_req !== 1'b1 || stall !== 1'b1) $display("FAIL mr_pending got %b%b exp 11", mem_req, stall); else passed++;
      #2 rst = 1'b1;
      #1;
      total++; if ({mem_req, stall, valid_out, err} !== 4'b0000) $display("FAIL mr_async got %b exp 0000", {mem_req, stall, valid_out, err}); else passed++;
      step();
      rst = 1'b0;
      issue(16'hCAFE, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0);
      step();
      idle_inputs();
      total++; if (wbdata !== 16'hCAFE || rdout !== 4'd2 || {valid_out, regwrite_out, stall} !== 3'b110)
         $display("FAIL mr_after got %h %0d %b exp cafe 2 110", wbdata, rdout, {valid_out, regwrite_out, stall});
      else passed++;
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_back_to_back();
      test_load();
      test_store();
      test_ack_in_idle();
      test_ack_timeout_race();
      test_timeout();
      test_illegal();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
